nes_pad_responder: RTL and testbench

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

---
 rtl/nes_pad_responder.sv | 134 +++++++++++++
 tb/tb_nes_pad_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_responder.sv
// NES controller responder: answers host latch/clock with serialized,
// active-low button bits.
module nes_pad_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nes_latch,
  input  logic       nes_clock,
  input  logic [7:0] buttons,
  output logic       nes_data,
  output logic       busy,
  output logic       read_done
);

  localparam int IW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] TMO  = IW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   latch_s;
  logic                   clk_s;
  logic                   clk_q;
  logic                   clk_rise;

  logic [7:0]    shreg, shreg_n;
  logic [3:0]    cnt, cnt_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic          data_n;
  logic          done_n;

  assign latch_s  = latch_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_q;

  // Bring host signals into clk domain and keep a delayed copy of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      clk_q      <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], nes_latch};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], nes_clock};
      clk_q      <= clk_s;
    end
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= 8'hFF;
      cnt       <= 4'd0;
      idle_cnt  <= '0;
      nes_data  <= 1'b1;
      read_done <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      idle_cnt  <= idle_n;
      nes_data  <= data_n;
      read_done <= done_n;
    end
  end

  // Next state; a high latch overrides everything, including clock edges.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    idle_n  = idle_cnt;
    data_n  = nes_data;
    done_n  = 1'b0;
    if (latch_s) begin
      state_n = LOAD;
      shreg_n = ~buttons;
      cnt_n   = 4'd0;
      idle_n  = '0;
      data_n  = ~buttons[0];
    end else begin
      unique case (state)
        IDLE: begin
          data_n = 1'b1;
          idle_n = '0;
        end
        LOAD: begin
          state_n = SHIFT;
          idle_n  = '0;
        end
        SHIFT: begin
          if (clk_rise) begin
            shreg_n = {1'b0, shreg[7:1]};
            cnt_n   = cnt + 4'd1;
            idle_n  = '0;
            data_n  = shreg[1];
            if (cnt == 4'd7) begin
              data_n  = 1'b0;
              done_n  = 1'b1;
              state_n = DONE;
            end
          end else if (TIMEOUT_CYCLES > 0 && idle_cnt >= TMO) begin
            state_n = IDLE;
            data_n  = 1'b1;
            idle_n  = '0;
          end else if (idle_cnt != IMAX) begin
            idle_n = idle_cnt + 1'b1;
          end
        end
        DONE: begin
          data_n = 1'b0;
          idle_n = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == SHIFT);

endmodule

// File: tb/tb_nes_pad_responder.sv
// Bench for nes_pad_responder: directed host frames, scoreboard
// of expected output levels checked by a negedge monitor.
module tb_nes_pad_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       nes_latch;
  logic       nes_clock;
  logic [7:0] buttons;
  logic       nes_data;
  logic       busy;
  logic       read_done;

  typedef struct {
    string name;
    logic  data;
    logic  busy;
    logic  rd;
    int    dcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   rd_cnt   = 0;
  int   done_exp = 0;
  logic rd_prev  = 1'b0;

  nes_pad_responder #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .nes_latch(nes_latch),
    .nes_clock(nes_clock),
    .buttons(buttons),
    .nes_data(nes_data),
    .busy(busy),
    .read_done(read_done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: count read_done pulses, check width, drain the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (read_done) rd_cnt++;
    if (rd_prev) begin
      checks++;
      if (read_done) begin
        errors++;
        $display("FAIL rd_width: read_done high 2 cycles, required 1");
      end
    end
    rd_prev = read_done;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (nes_data !== e.data || busy !== e.busy ||
          read_done !== e.rd || rd_cnt != e.dcnt) begin
        errors++;
        $display("FAIL %s: got data=%b busy=%b rd=%b dones=%0d, required data=%b busy=%b rd=%b dones=%0d",
                 e.name, nes_data, busy, read_done, rd_cnt,
                 e.data, e.busy, e.rd, e.dcnt);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic d, input logic b);
    exp_t e;
    e = '{nm, d, b, 1'b0, done_exp};
    exp_q.push_back(e);
    wait_clk(2);
  endtask

  task automatic host_clk();
    nes_clock = 1'b1;
    wait_clk(5);
    nes_clock = 1'b0;
    wait_clk(5);
  endtask

  task automatic do_latch(input string tag);
    nes_latch = 1'b1;
    wait_clk(5);
    chk({tag, "_load"}, ~buttons[0], 1'b1);
    nes_latch = 1'b0;
    wait_clk(5);
  endtask

  task automatic shift_all(input string tag, input logic [7:0] b);
    chk({tag, "_b0"}, ~b[0], 1'b1);
    for (int i = 1; i < 8; i++) begin
      host_clk();
      chk($sformatf("%s_b%0d", tag, i), ~b[i], 1'b1);
    end
    host_clk();
    done_exp++;
    chk({tag, "_end"}, 1'b0, 1'b0);
  endtask

  task automatic frame(input string tag, input logic [7:0] b);
    buttons = b;
    do_latch(tag);
    shift_all(tag, b);
  endtask

  initial begin
    rst_n     = 1'b0;
    nes_latch = 1'b0;
    nes_clock = 1'b0;
    buttons   = 8'h00;
    wait_clk(2);
    chk("reset", 1'b1, 1'b0);
    rst_n = 1'b1;
    wait_clk(3);
    chk("idle", 1'b1, 1'b0);

    // Scenario 1: A and Select pressed -> 0,1,0,1,1,1,1,1
    frame("s1", 8'b0000_0101);

    // Scenario 2: all pressed, extra clocks keep data low
    frame("s2", 8'hFF);
    for (int i = 0; i < 4; i++) begin
      host_clk();
      chk($sformatf("s2_extra%0d", i), 1'b0, 1'b0);
    end

    // Scenario 3: reload after 3 shifts, then a clean frame
    buttons = 8'h02;
    do_latch("s3a");
    chk("s3a_b0", 1'b1, 1'b1);
    host_clk();
    chk("s3a_b1", 1'b0, 1'b1);
    host_clk();
    chk("s3a_b2", 1'b1, 1'b1);
    host_clk();
    chk("s3a_b3", 1'b1, 1'b1);
    buttons = 8'h01;
    do_latch("s3_reload");
    shift_all("s3b", 8'h01);

    // Scenario 4: timeout after 2 shifts
    buttons = 8'h00;
    do_latch("s4");
    chk("s4_b0", 1'b1, 1'b1);
    host_clk();
    chk("s4_b1", 1'b1, 1'b1);
    host_clk();
    chk("s4_b2", 1'b1, 1'b1);
    wait_clk(60);
    chk("s4_timeout", 1'b1, 1'b0);
    host_clk();
    chk("s4_idle_clk", 1'b1, 1'b0);

    // Scenario 5: buttons tracked live while latch is high
    buttons   = 8'h01;
    nes_latch = 1'b1;
    wait_clk(5);
    chk("s5_load_a", 1'b0, 1'b1);
    buttons = 8'h80;
    wait_clk(5);
    chk("s5_load_r", 1'b1, 1'b1);
    nes_latch = 1'b0;
    wait_clk(5);
    buttons = 8'h00;
    shift_all("s5", 8'h80);

    // Scenario 6: reset mid-shift, then a clean frame
    buttons = 8'hAA;
    do_latch("s6a");
    chk("s6a_b0", 1'b1, 1'b1);
    host_clk();
    chk("s6a_b1", 1'b0, 1'b1);
    host_clk();
    chk("s6a_b2", 1'b1, 1'b1);
    host_clk();
    chk("s6a_b3", 1'b0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    chk("s6_rst", 1'b1, 1'b0);
    rst_n = 1'b1;
    wait_clk(3);
    chk("s6_post_rst", 1'b1, 1'b0);
    frame("s6b", 8'h5A);

    for (int k = 0; k < 100 && exp_q.size() > 0; k++) wait_clk(1);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
